// File: rtl/dcache_traffic_checker.sv
// Dcache load generator: LFSR writes to line-strided entries, then random reads checked against a shadow copy.
// Latency: one request per unstalled cycle; read data may return any number of cycles (>=1) after acceptance.
// Backpressure: dcache_stall_i holds the current request unchanged; reads also pause while OUTSTANDING are in flight. Optional: BYTE_SEL_TEST_EN.
module dcache_traffic_checker #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                NUM_ENTRIES = 16,
  parameter int                LINE_SHIFT  = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                NUM_READS   = 16,
  parameter int                OUTSTANDING = 4,
  parameter logic [31:0]       LFSR_SEED   = 32'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                dcache_stall_i,
  input  logic                dcache_rvalid_i,
  input  logic [DATA_W-1:0]   dcache_data_i,
  output logic [ADDR_W-1:0]   dcache_waddr_o,
  output logic [DATA_W-1:0]   dcache_wdata_o,
  output logic                dcache_wreq_o,
  output logic [ADDR_W-1:0]   dcache_raddr_o,
  output logic                dcache_rreq_o,
  output logic [DATA_W/8-1:0] dcache_sel_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [15:0]         err_count_o,
  output logic [7:0]          fail_index_o
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int SEL_W = DATA_W / 8;
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [31:0]       lfsr, lfsr_nxt;
  logic [IDX_W-1:0]  wr_idx, rd_idx, pop_idx;
  logic [15:0]       rd_cnt;
  logic [IDX_W-1:0]  idx_q [OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  occ;
  logic [DATA_W-1:0] shadow [NUM_ENTRIES];
  logic [SEL_W-1:0]  wr_sel;
  logic              fail_seen, fifo_full, fifo_empty, run_start;
  logic              wr_acc, rd_acc, pop, proto_err, mismatch;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [ADDR_W-1:0] entry_addr(input logic [IDX_W-1:0] idx);
    return BASE_ADDR + (ADDR_W'(idx) << LINE_SHIFT);
  endfunction

  // Galois form of x^32 + x^22 + x^2 + x + 1
  assign lfsr_nxt   = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
  assign rd_idx     = lfsr[IDX_W-1:0];
  assign pop_idx    = idx_q[rd_ptr];
  assign fifo_full  = (occ == CNT_W'(OUTSTANDING));
  assign fifo_empty = (occ == '0);
  assign run_start  = ((state == IDLE) || (state == DONE)) && start_i;
  assign wr_acc     = dcache_wreq_o && !dcache_stall_i;
  assign rd_acc     = dcache_rreq_o && !dcache_stall_i;
  assign pop        = dcache_rvalid_i && !fifo_empty;
  assign proto_err  = dcache_rvalid_i && fifo_empty;
  assign mismatch   = pop && (dcache_data_i != shadow[pop_idx]);
  assign pass_o     = done_o && (err_count_o == '0);

`ifdef BYTE_SEL_TEST_EN
  logic [NUM_ENTRIES-1:0] written;
  logic [3:0]             pat;

  always_comb begin
    pat = 4'b1111;
    case (2'(wr_idx))
      2'd1:    pat = 4'b0011;
      2'd2:    pat = 4'b1100;
      2'd3:    pat = 4'b0001;
      default: pat = 4'b1111;
    endcase
    wr_sel = '1;
    if (written[wr_idx]) begin
      for (int b = 0; b < SEL_W; b++) wr_sel[b] = pat[b % 4];
    end
  end

  // Shadow restarts from zero each run; the first write of every entry is full-width
  always_ff @(posedge clk) begin
    if (run_start) begin
      written <= '0;
      for (int e = 0; e < NUM_ENTRIES; e++) shadow[e] <= '0;
    end else if (wr_acc) begin
      written[wr_idx] <= 1'b1;
      for (int b = 0; b < SEL_W; b++) begin
        if (wr_sel[b]) shadow[wr_idx][8*b +: 8] <= dcache_wdata_o[8*b +: 8];
      end
    end
  end
`else
  always_comb wr_sel = '1;

  always_ff @(posedge clk) begin
    if (wr_acc) shadow[wr_idx] <= dcache_wdata_o;
  end
`endif

  always_ff @(posedge clk) begin
    if (rd_acc) idx_q[wr_ptr] <= rd_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    dcache_wreq_o  = 1'b0;
    dcache_rreq_o  = 1'b0;
    dcache_waddr_o = '0;
    dcache_wdata_o = '0;
    dcache_raddr_o = '0;
    dcache_sel_o   = '0;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    case (state)
      IDLE: if (start_i) state_nxt = WRITE;
      WRITE: begin
        busy_o         = 1'b1;
        dcache_wreq_o  = 1'b1;
        dcache_waddr_o = entry_addr(wr_idx);
        dcache_wdata_o = DATA_W'(lfsr);
        dcache_sel_o   = wr_sel;
        if (!dcache_stall_i && (wr_idx == IDX_W'(NUM_ENTRIES - 1))) state_nxt = READ;
      end
      READ: begin
        busy_o = 1'b1;
        if (!fifo_full) begin
          dcache_rreq_o  = 1'b1;
          dcache_raddr_o = entry_addr(rd_idx);
          dcache_sel_o   = '1;
          if (!dcache_stall_i && (rd_cnt == 16'(NUM_READS - 1))) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy_o = 1'b1;
        if (fifo_empty) state_nxt = DONE;
      end
      DONE: begin
        done_o = 1'b1;
        if (start_i) state_nxt = WRITE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr         <= LFSR_SEED;
      wr_idx       <= '0;
      rd_cnt       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      err_count_o  <= '0;
      fail_index_o <= '0;
      fail_seen    <= 1'b0;
    end else begin
      if (wr_acc || rd_acc) lfsr <= lfsr_nxt;
      if (run_start) begin
        wr_idx       <= '0;
        rd_cnt       <= '0;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        occ          <= '0;
        err_count_o  <= '0;
        fail_index_o <= '0;
        fail_seen    <= 1'b0;
      end else begin
        if (wr_acc) wr_idx <= wr_idx + 1'b1;
        if (rd_acc) begin
          rd_cnt <= rd_cnt + 16'd1;
          wr_ptr <= ptr_inc(wr_ptr);
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        if (rd_acc && !pop)      occ <= occ + 1'b1;
        else if (!rd_acc && pop) occ <= occ - 1'b1;
        if ((mismatch || proto_err) && (err_count_o != 16'hFFFF)) err_count_o <= err_count_o + 16'd1;
        if (mismatch && !fail_seen) begin
          fail_seen    <= 1'b1;
          fail_index_o <= 8'(pop_idx);
        end
      end
    end
  end

endmodule

// File: tb/tb_dcache_traffic_checker.sv
// Directed bench: behavioural cache model with variable latency, stall, corruption and spurious-rvalid injection.
module tb_dcache_traffic_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        dcache_stall_i  = 1'b0;
  logic        dcache_rvalid_i = 1'b0;
  logic [31:0] dcache_data_i   = '0;
  logic [31:0] dcache_waddr_o, dcache_wdata_o, dcache_raddr_o;
  logic        dcache_wreq_o, dcache_rreq_o, busy_o, done_o, pass_o;
  logic [3:0]  dcache_sel_o;
  logic [15:0] err_count_o;
  logic [7:0]  fail_index_o;

  dcache_traffic_checker dut (
    .clk(clk), .rst(rst), .start_i(start_i), .dcache_stall_i(dcache_stall_i),
    .dcache_rvalid_i(dcache_rvalid_i), .dcache_data_i(dcache_data_i),
    .dcache_waddr_o(dcache_waddr_o), .dcache_wdata_o(dcache_wdata_o), .dcache_wreq_o(dcache_wreq_o),
    .dcache_raddr_o(dcache_raddr_o), .dcache_rreq_o(dcache_rreq_o), .dcache_sel_o(dcache_sel_o),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_count_o(err_count_o),
    .fail_index_o(fail_index_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // ---------------- cache model (drives and samples on negedge) ----------------
  typedef struct {logic [31:0] d; int due;} rsp_t;
  rsp_t        rq[$];
  logic [31:0] mem [16] = '{default: 32'h0};
  logic [31:0] wlog_a [1024];
  logic [31:0] wlog_d [1024];
  logic [31:0] hold_a [8];
  logic [31:0] hold_d [8];
  int cyc = 0, out_n = 0, max_out = 0, wcnt = 0, rcnt = 0, overlap = 0, hold_n = 0, stall_left = 0;
  int lat = 1;
  int stall_req = 0, stall_ack = 0, corrupt_req = 0, corrupt_ack = 0, spur_req = 0, spur_ack = 0;

  always @(negedge clk) begin
    rsp_t r;
    cyc++;
    if (rst) begin
      rq.delete();
      out_n           = 0;
      max_out         = 0;
      stall_left      = 0;
      dcache_rvalid_i = 1'b0;
      dcache_stall_i  = 1'b0;
    end else begin
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        dcache_rvalid_i = 1'b1;
        dcache_data_i   = rq[0].d;
        void'(rq.pop_front());
        out_n--;
      end else if (spur_ack != spur_req) begin
        dcache_rvalid_i = 1'b1;
        dcache_data_i   = 32'h0;
        spur_ack++;
      end else begin
        dcache_rvalid_i = 1'b0;
      end
      if (stall_ack != stall_req && dcache_wreq_o && dcache_waddr_o == 32'h50) begin
        stall_left = 3;
        stall_ack++;
      end
      dcache_stall_i = (stall_left > 0);
      if (stall_left > 0) begin
        hold_a[hold_n] = dcache_waddr_o;
        hold_d[hold_n] = dcache_wdata_o;
        hold_n++;
        stall_left--;
      end
      if (dcache_wreq_o && dcache_rreq_o) overlap++;
      if (dcache_wreq_o && !dcache_stall_i) begin
        mem[dcache_waddr_o[7:4]] = dcache_wdata_o;
        wlog_a[wcnt] = dcache_waddr_o;
        wlog_d[wcnt] = dcache_wdata_o;
        wcnt++;
      end
      if (dcache_rreq_o && !dcache_stall_i) begin
        r.d = mem[dcache_raddr_o[7:4]];
        if (corrupt_ack != corrupt_req && dcache_raddr_o[7:4] == 4'd7) begin
          r.d = r.d ^ 32'h1;
          corrupt_ack++;
        end
        r.due = cyc + lat;
        rq.push_back(r);
        out_n++;
        rcnt++;
        if (out_n > max_out) max_out = out_n;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_to_done(input string tag);
    int n = 0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    while (!done_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(done_o), 32'd1);
  endtask

  // All 16 writes of a run that began from the reset seed
  task automatic check_writes_from_seed(input string tag, input int base);
    logic [31:0] e = 32'hACE1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s_waddr%0d", tag, i), wlog_a[base+i], 32'(i) << 4);
      chk($sformatf("%s_wdata%0d", tag, i), wlog_d[base+i], e);
      e = lfsr_next(e);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_wreq"},  32'(dcache_wreq_o), 32'd0);
    chk({tag, "_rreq"},  32'(dcache_rreq_o), 32'd0);
    chk({tag, "_addr"},  dcache_waddr_o | dcache_raddr_o | dcache_wdata_o, 32'd0);
    chk({tag, "_sel"},   32'(dcache_sel_o), 32'd0);
    chk({tag, "_busy"},  32'(busy_o), 32'd0);
    chk({tag, "_done"},  32'(done_o), 32'd0);
    chk({tag, "_pass"},  32'(pass_o), 32'd0);
    chk({tag, "_err"},   32'(err_count_o), 32'd0);
    chk({tag, "_fidx"},  32'(fail_index_o), 32'd0);
  endtask

  initial begin
    int wb, rb, n;
    logic [31:0] e5, e6;
    rst     = 1'b1;
    start_i = 1'b0;
    do_reset();
    check_idle_outputs("reset");

    // spurious rvalid while idle counts as a protocol error
    spur_req++;
    repeat (3) @(negedge clk);
    chk("idle_spur_err", 32'(err_count_o), 32'd1);

    // Test 1: ideal cache
    wb = wcnt; rb = rcnt;
    run_to_done("t1");
    chk("t1_pass", 32'(pass_o), 32'd1);
    chk("t1_err", 32'(err_count_o), 32'd0);
    chk("t1_busy", 32'(busy_o), 32'd0);
    chk("t1_nwr", 32'(wcnt - wb), 32'd16);
    chk("t1_nrd", 32'(rcnt - rb), 32'd16);
    chk("t1_wdata0_const", wlog_d[wb], 32'h0000_ACE1);
    chk("t1_wdata1_const", wlog_d[wb+1], 32'h8020_5673);
    check_writes_from_seed("t1", wb);

    // Test 2: 3-cycle stall on write 5
    do_reset();
    e5 = 32'hACE1;
    for (int i = 0; i < 5; i++) e5 = lfsr_next(e5);
    e6 = lfsr_next(e5);
    stall_req++;
    wb = wcnt; hold_n = 0;
    run_to_done("t2");
    chk("t2_hold_cycles", 32'(hold_n), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_hold_addr%0d", i), hold_a[i], 32'h50);
      chk($sformatf("t2_hold_data%0d", i), hold_d[i], e5);
    end
    chk("t2_nwr", 32'(wcnt - wb), 32'd16);
    chk("t2_w5", wlog_d[wb+5], e5);
    chk("t2_w6", wlog_d[wb+6], e6);
    chk("t2_pass", 32'(pass_o), 32'd1);

    // Test 3: one corrupted read of entry 7 (repeat runs until entry 7 is read)
    do_reset();
    corrupt_req++;
    n = 0;
    while (corrupt_ack != corrupt_req && n < 12) begin
      run_to_done("t3");
      n++;
    end
    chk("t3_corrupt_seen", 32'(corrupt_req - corrupt_ack), 32'd0);
    chk("t3_err", 32'(err_count_o), 32'd1);
    chk("t3_fidx", 32'(fail_index_o), 32'd7);
    chk("t3_pass", 32'(pass_o), 32'd0);

    // Test 4: latency 6, queue limit 4
    lat = 6;
    do_reset();
    run_to_done("t4");
    chk("t4_max_out", 32'(max_out), 32'd4);
    chk("t4_pass", 32'(pass_o), 32'd1);
    chk("t4_err", 32'(err_count_o), 32'd0);
    lat = 1;

    // Test 5: spurious rvalid after drain
    spur_req++;
    repeat (3) @(negedge clk);
    chk("t5_err", 32'(err_count_o), 32'd1);
    chk("t5_pass", 32'(pass_o), 32'd0);
    chk("t5_done", 32'(done_o), 32'd1);

    // Test 6: reset mid-READ, then rerun from seed
    do_reset();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (!dcache_rreq_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_read", 32'(dcache_rreq_o), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("t6_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wb = wcnt; rb = rcnt;
    run_to_done("t6");
    chk("t6_pass", 32'(pass_o), 32'd1);
    chk("t6_err", 32'(err_count_o), 32'd0);
    chk("t6_nrd", 32'(rcnt - rb), 32'd16);
    check_writes_from_seed("t6", wb);
    chk("no_wr_rd_overlap", 32'(overlap), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d/%0d checks expected completion", n_pass, n_chk);
    $fatal(1);
  end

endmodule
